// File: rtl/lfpm_serial_mul.sv
// Byte-serial Mitchell (log-domain) approximate floating-point multiplier with a valid/ready result stream.
// Optional macro LFPM_FLAGS_EN adds a flags[2:0] = {nan, ovf, unf} output.
module lfpm_serial_mul #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] a_in,
  input  logic [BUS_W-1:0] b_in,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
`ifdef LFPM_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int NBEATS = (W + BUS_W - 1) / BUS_W;
  localparam int PW     = NBEATS * BUS_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int M      = EXP_W + MAN_W + 2;
  localparam int BIAS   = (2 ** (EXP_W - 1)) - 1;

  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [EXP_W-1:0]    EXP_ONES  = '1;
  localparam logic signed [M-1:0] BIAS_SH   = M'(BIAS) <<< MAN_W;
  localparam logic signed [M-1:0] MIN_NORM  = M'(1) <<< MAN_W;
  localparam logic signed [M-1:0] MAX_EXP   = M'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, SEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic [PW-1:0]    res_q, res_d;
  logic [BUS_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  // Operand field decode (bits above W in the padded registers are never looked at)
  logic             sa, sb, sgn;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign {sa, ea, ma} = a_q[W-1:0];
  assign {sb, eb, mb} = b_q[W-1:0];
  assign sgn = sa ^ sb;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  // Adding the packed {exp,man} fields is a log2 addition; subtracting the
  // shifted bias re-centres the exponent. No Mitchell error correction.
  logic signed [M-1:0] mag, mag_exp;
  assign mag     = $signed({2'b00, ea, ma}) + $signed({2'b00, eb, mb}) - BIAS_SH;
  assign mag_exp = mag >>> MAN_W;

  logic is_nan, is_inf, is_zero, is_unf, is_ovf;
  assign is_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign is_inf  = a_inf || b_inf;
  assign is_zero = a_zero || b_zero;
  assign is_unf  = (mag < MIN_NORM);
  assign is_ovf  = (mag_exp >= MAX_EXP);

  logic [W-1:0] res_w;

  always_comb begin
    res_w = '0;
    if (is_nan) begin
      res_w[W-2 -: EXP_W] = EXP_ONES;
      res_w[MAN_W-1]      = 1'b1;
    end else if (is_inf) begin
      res_w = {sgn, EXP_ONES, {MAN_W{1'b0}}};
    end else if (is_zero || is_unf) begin
      res_w = {sgn, {(W-1){1'b0}}};
    end else if (is_ovf) begin
      res_w = {sgn, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      res_w = {sgn, mag[EXP_W+MAN_W-1:0]};
    end
  end

  logic [PW-1:0] res_pad;
  assign res_pad = PW'(res_w);

  logic [BUS_W-1:0] res_beat [NBEATS];

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
    assign res_beat[gi] = res_q[gi*BUS_W +: BUS_W];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (ena) begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (in_valid) begin
            a_d[cnt_q*BUS_W +: BUS_W] = a_in;
            b_d[cnt_q*BUS_W +: BUS_W] = b_in;
            if (cnt_q == LAST_BEAT) begin
              state_d = CALC;
              cnt_d   = '0;
            end else begin
              state_d = LOAD;
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
        CALC: begin
          res_d       = res_pad;
          cnt_d       = '0;
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_data_d  = res_pad[BUS_W-1:0];
          out_last_d  = (LAST_BEAT == '0);
        end
        SEND: begin
          if (out_ready) begin
            if (cnt_q == LAST_BEAT) begin
              state_d     = IDLE;
              cnt_d       = '0;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              out_data_d  = '0;
            end else begin
              cnt_d      = cnt_q + 1'b1;
              out_data_d = res_beat[cnt_d];
              out_last_d = (cnt_d == LAST_BEAT);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

`ifdef LFPM_FLAGS_EN
  // Flags follow the same priority as the result mux: a zero operand is not an underflow.
  logic [2:0] calc_flags;
  logic [2:0] flags_q, flags_d;

  assign calc_flags = {is_nan,
                       !is_nan && !is_inf && !is_zero && !is_unf && is_ovf,
                       !is_nan && !is_inf && !is_zero && is_unf};

  always_comb begin
    flags_d = flags_q;
    if (ena) begin
      if (state_q == CALC) begin
        flags_d = calc_flags;
      end else if (state_q == SEND && out_ready && cnt_q == LAST_BEAT) begin
        flags_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_lfpm_serial_mul.sv
// Directed bench for lfpm_serial_mul (FP16 defaults); flags checked when LFPM_FLAGS_EN is defined.
module tb_lfpm_serial_mul;

  logic       clk = 1'b0;
  logic       rst_n, ena, in_valid, out_ready;
  logic [7:0] a_in, b_in, out_data;
  logic       out_valid, out_last, busy;
`ifdef LFPM_FLAGS_EN
  logic [2:0] flags;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfpm_serial_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy)
`ifdef LFPM_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Two input beats, LSB first, with optional idle gap (junk on the bus) between them.
  task automatic feed(input logic [15:0] a, input logic [15:0] b, input int gap);
    @(negedge clk);
    in_valid = 1'b1; a_in = a[7:0]; b_in = b[7:0];
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a_in = 8'hFF; b_in = 8'hFF;
    end
    @(negedge clk);
    in_valid = 1'b1; a_in = a[15:8]; b_in = b[15:8];
    @(negedge clk);
    in_valid = 1'b0; a_in = 8'h00; b_in = 8'h00;
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] expv, input logic [2:0] xf, input int gap);
    logic [7:0] d0;
    logic       v0, l0;
    feed(a, b, gap);
    check({tag, "_calc_no_valid"}, 32'(out_valid), 32'(0));
    @(negedge clk);
    v0 = out_valid; d0 = out_data; l0 = out_last;
`ifdef LFPM_FLAGS_EN
    check({tag, "_flags"}, 32'(flags), 32'(xf));
`endif
    @(negedge clk);
    check({tag, "_result"}, 32'({out_data, d0}), 32'(expv));
    check({tag, "_vl"}, 32'({v0, l0, out_valid, out_last}), 32'(4'b1011));
    $display("op %s a=%h b=%h res=%h%h exp=%h flags_exp=%b", tag, a, b, out_data, d0, expv, xf);
    @(negedge clk);
    check({tag, "_idle"}, 32'({busy, out_valid, out_last}), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; a_in = 8'h00; b_in = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_last", 32'(out_last), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_data", 32'(out_data), 32'(0));
`ifdef LFPM_FLAGS_EN
    check("rst_flags", 32'(flags), 32'(0));
`endif
    rst_n = 1'b1;

    op("basic", 16'h3E00, 16'h4200, 16'h4400, 3'b000, 0);
`ifdef LFPM_FLAGS_EN
    check("basic_flags_clr", 32'(flags), 32'(0));
`endif
    op("sign",  16'hBC00, 16'h4000, 16'hC000, 3'b000, 0);
    op("ovf",   16'h7800, 16'h7800, 16'h7C00, 3'b010, 0);
    op("nan",   16'h0000, 16'h7C00, 16'h7E00, 3'b100, 0);
    op("unf",   16'h0400, 16'h0400, 16'h0000, 3'b001, 0);
    op("zero",  16'h8000, 16'h4000, 16'h8000, 3'b000, 0);
    op("mant",  16'h3C01, 16'h4000, 16'h4001, 3'b000, 0);
    op("gap",   16'h3E00, 16'h4200, 16'h4400, 3'b000, 2);

    // Consumer stalls on beat 0 for three cycles.
    out_ready = 1'b0;
    feed(16'h3E00, 16'h4200, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b0, 8'h00}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_beat1", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b1, 8'h44}));
    $display("op bp a=3e00 b=4200 beat1=%h", out_data);
    @(negedge clk);
    check("bp_idle", 32'({busy, out_valid}), 32'(0));

    // Enable dropped for two cycles while beat 0 is presented.
    feed(16'h3C01, 16'h4000, 0);
    @(negedge clk);
    check("ena_beat0", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b0, 8'h01}));
    ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ena_frozen", 32'({busy, out_valid, out_last, out_data}), 32'({1'b1, 1'b1, 1'b0, 8'h01}));
    end
    ena = 1'b1;
    @(negedge clk);
    check("ena_beat1", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b1, 8'h40}));
    $display("op ena a=3c01 b=4000 beat1=%h", out_data);
    @(negedge clk);
    check("ena_idle", 32'({busy, out_valid}), 32'(0));

    // Abort after the first operand beat; the next operation must start clean.
    @(negedge clk);
    in_valid = 1'b1; a_in = 8'h01; b_in = 8'h77;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'({busy, out_valid, out_last, out_data}), 32'(0));
    $display("op midrst busy=%b out_valid=%b", busy, out_valid);
    rst_n = 1'b1;
    op("after_rst", 16'h3E00, 16'h4200, 16'h4400, 3'b000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfpm_serial_mul.md
Name: lfpm_serial_mul

Overview:
- Parametrised successor to the fixed-FP16 logarithmic approximate FP multiplier (Mitchell algorithm).
- Operands arrive byte-serially, least-significant byte first, on two parallel input buses. The result leaves byte-serially under a valid/ready handshake.
- Format widths and bus width are parameters.
- Sits inside the tt_um_* top. The top maps a_in, b_in and out_data onto the ui_in, uio_in and uo_out pins.

Parameters:
- EXP_W, 5, exponent field width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 10, mantissa field width.
- BUS_W, 8, serial bus width.
- Derived: W = 1+EXP_W+MAN_W; NBEATS = ceil(W/BUS_W). Defaults give FP16 in 2 beats.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, synchronous active-low reset.
- ena, in, 1, enable; when 0, all state and outputs hold.
- in_valid, in, 1, the current a_in/b_in beat is valid.
- a_in, in, BUS_W, operand A beat.
- b_in, in, BUS_W, operand B beat.
- out_ready, in, 1, consumer accepts the out_data beat.
- out_data, out, BUS_W, result beat.
- out_valid, out, 1, out_data is valid.
- out_last, out, 1, marks the final result beat.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - state=IDLE, beat counter=0, operand and result registers=0;
  - out_data=0, out_valid=0, out_last=0, busy=0.
  - Reset in any state, including mid-LOAD and mid-SEND, aborts the operation; partial operands are discarded.
- FSM, which advances only when ena=1:
  - IDLE: in_valid=1 captures beat 0 and moves to LOAD (or straight to CALC if NBEATS=1).
  - LOAD: each in_valid=1 captures the next beat into bits [k*BUS_W +: BUS_W]. Beats with in_valid=0 are skipped and the counter holds. Capturing beat NBEATS-1 moves to CALC.
  - CALC: one cycle. Registers the W-bit result into the output shift register, sets beat counter=0, moves to SEND.
  - SEND: out_valid=1 and out_data = result beat k. Each cycle with out_ready=1 advances k. out_last=1 on beat NBEATS-1. A handshake on the last beat returns to IDLE with out_valid=0.
  - While out_ready=0, out_data, out_valid and out_last hold.
- in_valid is ignored in CALC and SEND; there is no input buffering.
- Latency: last input beat accepted at edge N; at edge N+1, out_valid=1 with beat 0 (assuming ena=1 throughout).
- Input bits at index W and above in the final beat are ignored. Output bits at index W and above are 0.
- Arithmetic, signed width EXP_W+MAN_W+2:
  - sign = sa ^ sb.
  - mag = {ea,ma} + {eb,mb} - (Bias << MAN_W). This is Mitchell log-domain addition with no error correction.
- Special cases, in priority order:
  1. Either operand NaN, or inf×0: canonical NaN = {0, all-ones exponent, 1, zeros}.
  2. Either operand inf: {sign, all-ones exponent, 0}.
  3. Either exponent 0 (zero or subnormal, flushed to zero): {sign, 0}.
  4. mag < (1 << MAN_W) (underflow): {sign, 0}.
  5. mag >> MAN_W >= all-ones exponent (overflow): {sign, inf}.
  6. Otherwise: {sign, mag[EXP_W+MAN_W-1:0]}.
- ena=0 in any state freezes the FSM, counters and handshake. Inputs are not sampled while ena=0.

Optional Feature:
- Macro LFPM_FLAGS_EN.
- When defined, adds output port flags[2:0] = {nan, ovf, unf}:
  - reset value 0;
  - registered at CALC alongside the result, held through SEND, cleared when returning to IDLE;
  - unf is set only by case 4, not by a zero operand (case 3).
- When undefined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> out_valid=0, out_last=0, busy=0, out_data=0x00.
- A=0x3E00, B=0x4200 (1.5×3.0); beats (a,b) = (0x00,0x00), (0x3E,0x42); out_ready=1 -> beats 0x00, then 0x44 with out_last=1. Result is 0x4400 (4.0, Mitchell approximation). out_valid rises one edge after the last input beat.
- Sign and overflow:
  - A=0xBC00, B=0x4000 -> 0xC000.
  - A=0x7800, B=0x7800 -> 0x7C00; flags=3'b010 when LFPM_FLAGS_EN is defined.
- Specials:
  - A=0x0000, B=0x7C00 -> 0x7E00 with nan flag.
  - A=0x0400, B=0x0400 -> 0x0000 with unf flag.
  - A=0x8000, B=0x4000 -> 0x8000.
- Backpressure and gaps:
  - in_valid=0 for 2 cycles between input beats -> same result as the no-gap case.
  - out_ready=0 for 3 cycles on beat 0 -> out_data=0x00 held, no beat lost.
  - ena=0 for 2 cycles mid-SEND -> everything freezes.
- Reset mid-op: rst_n=0 after beat 0 of an operation -> IDLE, busy=0. The next full operation with A=0x3E00, B=0x4200 yields 0x4400.
